// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the LSB/IFU <-> byte-wide RAM controller:
// slot tag width, access-length codes, FSM states and IO address decode.
package mem_ctrl_pkg;

  localparam int LSB_CAP_BIT = 4;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_FETCH,
    S_IOWAIT
  } state_t;

  function automatic logic [2:0] len_beats(input logic [1:0] len);
    case (len)
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_io(input logic [31:0] addr, input int msb);
    return addr[msb -: 2] == 2'b11;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Sole master of the byte-wide RAM bus: serialises one LSB load/store or IFU fetch
// into little-endian byte beats. Define MEM_IO_STALL_EN to gate IO-space stores on io_buffer_full.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IO_MSB = 17
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   clear,
  input  logic                   lsb_req,
  input  logic [LSB_CAP_BIT-1:0] lsb_pos,
  input  logic                   lsb_ls,
  input  logic [1:0]             lsb_len,
  input  logic [31:0]            lsb_addr,
  input  logic [31:0]            lsb_val,
  output logic                   lsb_finished,
  output logic [31:0]            lsb_rdata,
  output logic [LSB_CAP_BIT-1:0] lsb_rpos,
  output logic                   mem_busy,
  input  logic                   if_req,
  input  logic [31:0]            if_addr,
  output logic                   if_ready,
  output logic [31:0]            if_data,
  input  logic [7:0]             mem_din,
  output logic [7:0]             mem_dout,
  output logic [ADDR_W-1:0]      mem_a,
  output logic                   mem_wr,
  input  logic                   io_buffer_full
);

  state_t                 r_state, w_state_nxt;
  logic [31:0]            r_addr, r_val, r_data;
  logic [2:0]             r_cnt, r_n;
  logic [LSB_CAP_BIT-1:0] r_pos, r_rpos;
  logic                   r_suppress, r_finished, r_if_ready, r_rdy_d;
  logic [31:0]            r_rdata, r_if_data;
  logic [7:0]             r_din_hold;

  logic                   w_acc_lsb, w_acc_if, w_rd_beat, w_wr_beat, w_cap;
  logic                   w_rd_done, w_wr_done, w_cnt_inc;
  logic                   w_io_hold, w_to_io, w_is_io;
  logic [7:0]             w_din;
  logic [1:0]             w_cap_idx;
  logic [31:0]            w_data_cap;

  assign w_is_io = is_io(lsb_addr, IO_MSB);

`ifdef MEM_IO_STALL_EN
  assign w_io_hold = io_buffer_full;
  assign w_to_io   = w_is_io;
`else
  logic [1:0] w_unused_io;
  assign w_unused_io = {io_buffer_full, w_is_io};
  assign w_io_hold   = 1'b0;
  assign w_to_io     = 1'b0;
`endif

  // RAM returns data one cycle after the address, so the byte in flight when
  // rdy_in drops is parked here and used on the first cycle after resume.
  assign w_din      = r_rdy_d ? mem_din : r_din_hold;
  assign w_cap_idx  = r_cnt[1:0] - 2'd1;
  assign w_data_cap = r_data | (32'(w_din) << {w_cap_idx, 3'b000});

  always_comb begin
    w_state_nxt = r_state;
    w_acc_lsb   = 1'b0;
    w_acc_if    = 1'b0;
    w_rd_beat   = 1'b0;
    w_wr_beat   = 1'b0;
    w_cap       = 1'b0;
    w_rd_done   = 1'b0;
    w_wr_done   = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!clear && !r_finished && !r_if_ready) begin
          if (lsb_req) begin
            w_acc_lsb = 1'b1;
            if (!lsb_ls)      w_state_nxt = S_LOAD;
            else if (w_to_io) w_state_nxt = S_IOWAIT;
            else              w_state_nxt = S_STORE;
          end else if (if_req) begin
            w_acc_if    = 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_LOAD, S_FETCH: begin
        w_rd_beat = (r_cnt < r_n);
        if (clear) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cap = (r_cnt != 3'd0);
          if (r_cnt == r_n) begin
            w_rd_done   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      S_STORE: begin
        w_wr_beat = 1'b1;
        w_cnt_inc = 1'b1;
        if (r_cnt == r_n - 3'd1) begin
          w_wr_done   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_IOWAIT: begin
        if (!w_io_hold) begin
          w_wr_beat = 1'b1;
          w_cnt_inc = 1'b1;
          if (r_cnt == r_n - 3'd1) begin
            w_wr_done   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_val      <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_n        <= '0;
      r_pos      <= '0;
      r_rpos     <= '0;
      r_suppress <= 1'b0;
      r_finished <= 1'b0;
      r_if_ready <= 1'b0;
      r_rdata    <= '0;
      r_if_data  <= '0;
      r_rdy_d    <= 1'b1;
      r_din_hold <= '0;
    end else begin
      r_rdy_d <= rdy_in;
      if (!rdy_in && r_rdy_d) r_din_hold <= mem_din;
      if (rdy_in) begin
        r_state    <= w_state_nxt;
        r_finished <= 1'b0;
        r_if_ready <= 1'b0;
        if (w_acc_lsb) begin
          r_addr     <= lsb_addr;
          r_val      <= lsb_val;
          r_pos      <= lsb_pos;
          r_n        <= len_beats(lsb_len);
          r_cnt      <= '0;
          r_data     <= '0;
          r_suppress <= 1'b0;
        end else if (w_acc_if) begin
          r_addr     <= if_addr;
          r_n        <= 3'd4;
          r_cnt      <= '0;
          r_data     <= '0;
          r_suppress <= 1'b0;
        end
        if (w_cap)     r_data <= w_data_cap;
        if (w_cnt_inc) r_cnt  <= r_cnt + 3'd1;
        if (w_rd_done) begin
          if (r_state == S_LOAD) begin
            r_finished <= 1'b1;
            r_rdata    <= w_data_cap;
            r_rpos     <= r_pos;
          end else begin
            r_if_ready <= 1'b1;
            r_if_data  <= w_data_cap;
          end
        end
        // A flushed store still drains its beats but must not report completion.
        if ((r_state == S_STORE || r_state == S_IOWAIT) && clear) r_suppress <= 1'b1;
        if (w_wr_done && !(r_suppress || clear)) begin
          r_finished <= 1'b1;
          r_rdata    <= '0;
          r_rpos     <= r_pos;
        end
      end
    end
  end

  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    if (w_rd_beat || w_wr_beat) mem_a = ADDR_W'(r_addr + 32'(r_cnt));
    if (w_wr_beat) mem_dout = r_val[{r_cnt[1:0], 3'b000} +: 8];
  end

  assign mem_wr       = w_wr_beat & rdy_in & ~rst_in;
  assign lsb_finished = r_finished;
  assign lsb_rdata    = r_rdata;
  assign lsb_rpos     = r_rpos;
  assign if_ready     = r_if_ready;
  assign if_data      = r_if_data;
  assign mem_busy     = (r_state != S_IDLE) | lsb_req | r_finished;

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomised self-checking bench for mem_ctrl against a byte-array memory model.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic                   clk_in = 1'b0;
  logic                   rst_in, rdy_in, clear, lsb_req, lsb_ls, if_req, io_buffer_full;
  logic [LSB_CAP_BIT-1:0] lsb_pos, lsb_rpos;
  logic [1:0]             lsb_len;
  logic [31:0]            lsb_addr, lsb_val, lsb_rdata, if_addr, if_data, mem_a;
  logic                   lsb_finished, mem_busy, if_ready, mem_wr;
  logic [7:0]             mem_din, mem_dout;

  always #5 clk_in = ~clk_in;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .lsb_req(lsb_req), .lsb_pos(lsb_pos), .lsb_ls(lsb_ls), .lsb_len(lsb_len),
    .lsb_addr(lsb_addr), .lsb_val(lsb_val), .lsb_finished(lsb_finished),
    .lsb_rdata(lsb_rdata), .lsb_rpos(lsb_rpos), .mem_busy(mem_busy),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  logic [7:0] ram     [0:262143];
  logic [7:0] ref_mem [0:262143];

  always @(posedge clk_in) begin
    mem_din <= ram[mem_a[17:0]];
    if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
  end

  int n_checks = 0;
  int n_errors = 0;

  int          fin_cyc, fin_cnt, ifr_cyc, ifr_cnt;
  logic [31:0] obs_rdata, obs_idata;
  logic [3:0]  obs_rpos;
  typedef struct { int cyc; logic [31:0] a; logic [7:0] d; } wr_t;
  wr_t         wq[$];
  logic [31:0] a_log [0:23];
  logic        busy_log [0:23];
  logic        wr_log [0:23];

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
    logic [31:0] r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = ref_mem[18'(a + 32'(k))];
    return r;
  endfunction

  task automatic idle_inputs();
    lsb_req = 0; lsb_ls = 0; lsb_len = 0; lsb_addr = 0; lsb_val = 0; lsb_pos = 0;
    if_req = 0; if_addr = 0; clear = 0; rdy_in = 1; rst_in = 0; io_buffer_full = 0;
  endtask

  // Drives one scenario for 24 cycles (cycle 0 = request cycle) and records what the DUT did.
  task automatic run_op(input bit do_lsb, input bit ls, input logic [1:0] len,
                        input logic [31:0] addr, input logic [31:0] val, input logic [3:0] pos,
                        input bit do_if, input logic [31:0] faddr, input int clr_cyc,
                        input int rdy_from, input int rdy_n, input int rst_cyc, input int full_n);
    fin_cyc = -1; fin_cnt = 0; ifr_cyc = -1; ifr_cnt = 0;
    obs_rdata = 'x; obs_idata = 'x; obs_rpos = 'x;
    wq.delete();
    for (int c = 0; c < 24; c++) begin
      lsb_req = do_lsb && (c == 0);
      lsb_ls = ls; lsb_len = len; lsb_addr = addr; lsb_val = val; lsb_pos = pos;
      if_req = do_if && (ifr_cyc < 0);
      if_addr = faddr;
      clear = (c == clr_cyc);
      rdy_in = !(c >= rdy_from && c < rdy_from + rdy_n);
      rst_in = (c == rst_cyc);
      io_buffer_full = (c >= 1 && c <= full_n);
      #1;
      a_log[c] = mem_a; busy_log[c] = mem_busy; wr_log[c] = mem_wr;
      if (mem_wr) wq.push_back('{c, mem_a, mem_dout});
      if (lsb_finished) begin
        fin_cnt++;
        if (fin_cyc < 0) begin fin_cyc = c; obs_rdata = lsb_rdata; obs_rpos = lsb_rpos; end
      end
      if (if_ready) begin
        ifr_cnt++;
        if (ifr_cyc < 0) begin ifr_cyc = c; obs_idata = if_data; end
      end
      @(negedge clk_in);
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_in = 1;
    repeat (3) @(negedge clk_in);
    rst_in = 0;
    #1;
    n_checks++; if (lsb_finished !== 1'b0) begin n_errors++; $display("FAIL reset_finished got %b want 0", lsb_finished); end
    n_checks++; if (if_ready !== 1'b0) begin n_errors++; $display("FAIL reset_if_ready got %b want 0", if_ready); end
    n_checks++; if (mem_wr !== 1'b0) begin n_errors++; $display("FAIL reset_mem_wr got %b want 0", mem_wr); end
    n_checks++; if (mem_dout !== 8'h0) begin n_errors++; $display("FAIL reset_mem_dout got %h want 0", mem_dout); end
    n_checks++; if (mem_a !== 32'h0) begin n_errors++; $display("FAIL reset_mem_a got %h want 0", mem_a); end
    n_checks++; if (lsb_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rdata got %h want 0", lsb_rdata); end
    n_checks++; if (if_data !== 32'h0) begin n_errors++; $display("FAIL reset_if_data got %h want 0", if_data); end
    n_checks++; if (mem_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", mem_busy); end
    @(negedge clk_in);
  endtask

  task automatic test_load_word();
    logic [7:0] b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 4; k++) begin ram['h100 + k] = b[k]; ref_mem['h100 + k] = b[k]; end
    run_op(1, 0, LEN_W, 32'h100, 0, 4'h9, 0, 0, -1, -1, 0, -1, 0);
    n_checks++; if (fin_cyc != 6) begin n_errors++; $display("FAIL lw_finish_cycle got %0d want 6", fin_cyc); end
    n_checks++; if (fin_cnt != 1) begin n_errors++; $display("FAIL lw_finish_count got %0d want 1", fin_cnt); end
    n_checks++; if (obs_rdata !== 32'h44332211) begin n_errors++; $display("FAIL lw_rdata got %h want 44332211", obs_rdata); end
    n_checks++; if (obs_rpos !== 4'h9) begin n_errors++; $display("FAIL lw_rpos got %h want 9", obs_rpos); end
  endtask

  task automatic test_store_half();
    run_op(1, 1, LEN_H, 32'h200, 32'h0000ABCD, 4'h3, 0, 0, -1, -1, 0, -1, 0);
    ref_mem['h200] = 8'hCD; ref_mem['h201] = 8'hAB;
    n_checks++;
    if (wq.size() != 2) begin
      n_errors++; $display("FAIL sh_beats got %0d want 2", wq.size());
    end else begin
      if (wq[0].cyc != 1 || wq[0].a !== 32'h200 || wq[0].d !== 8'hCD) begin
        n_errors++; $display("FAIL sh_beat0 got c%0d %h/%h want c1 200/CD", wq[0].cyc, wq[0].a, wq[0].d);
      end
      n_checks++;
      if (wq[1].cyc != 2 || wq[1].a !== 32'h201 || wq[1].d !== 8'hAB) begin
        n_errors++; $display("FAIL sh_beat1 got c%0d %h/%h want c2 201/AB", wq[1].cyc, wq[1].a, wq[1].d);
      end
    end
    n_checks++; if (fin_cyc != 3) begin n_errors++; $display("FAIL sh_finish_cycle got %0d want 3", fin_cyc); end
    n_checks++; if (obs_rdata !== 32'h0) begin n_errors++; $display("FAIL sh_rdata got %h want 0", obs_rdata); end
    n_checks++; if (obs_rpos !== 4'h3) begin n_errors++; $display("FAIL sh_rpos got %h want 3", obs_rpos); end
  endtask

  task automatic test_random_ops();
    for (int it = 0; it < 40; it++) begin
      int          kind = $urandom_range(0, 2);
      logic [1:0]  len  = 2'($urandom_range(0, 2));
      int          n    = 1 << len;
      logic [31:0] addr = 32'($urandom_range(0, 'h2FFF0));
      logic [31:0] val  = $urandom;
      logic [3:0]  pos  = 4'($urandom);
      if (kind == 0) begin
        logic [31:0] exp = ref_load(addr, n);
        run_op(1, 0, len, addr, val, pos, 0, 0, -1, -1, 0, -1, 0);
        n_checks++; if (fin_cyc != n + 2) begin n_errors++; $display("FAIL rnd_ld_cycle it%0d got %0d want %0d", it, fin_cyc, n + 2); end
        n_checks++; if (obs_rdata !== exp) begin n_errors++; $display("FAIL rnd_ld_data it%0d got %h want %h", it, obs_rdata, exp); end
        n_checks++; if (obs_rpos !== pos) begin n_errors++; $display("FAIL rnd_ld_pos it%0d got %h want %h", it, obs_rpos, pos); end
        n_checks++; if (wq.size() != 0) begin n_errors++; $display("FAIL rnd_ld_nowrite it%0d got %0d want 0", it, wq.size()); end
      end else if (kind == 1) begin
        run_op(1, 1, len, addr, val, pos, 0, 0, -1, -1, 0, -1, 0);
        n_checks++; if (fin_cyc != n + 1) begin n_errors++; $display("FAIL rnd_st_cycle it%0d got %0d want %0d", it, fin_cyc, n + 1); end
        n_checks++; if (obs_rpos !== pos) begin n_errors++; $display("FAIL rnd_st_pos it%0d got %h want %h", it, obs_rpos, pos); end
        n_checks++;
        if (wq.size() != n) begin
          n_errors++; $display("FAIL rnd_st_beats it%0d got %0d want %0d", it, wq.size(), n);
        end else begin
          for (int k = 0; k < n; k++) begin
            n_checks++;
            if (wq[k].cyc != k + 1 || wq[k].a !== addr + 32'(k) || wq[k].d !== val[8*k +: 8]) begin
              n_errors++;
              $display("FAIL rnd_st_beat it%0d k%0d got c%0d %h/%h want c%0d %h/%h",
                       it, k, wq[k].cyc, wq[k].a, wq[k].d, k + 1, addr + 32'(k), val[8*k +: 8]);
            end
          end
        end
        for (int k = 0; k < n; k++) ref_mem[18'(addr + 32'(k))] = val[8*k +: 8];
      end else begin
        logic [31:0] fa  = addr & ~32'h3;
        logic [31:0] exp = ref_load(fa, 4);
        run_op(0, 0, 0, 0, 0, 0, 1, fa, -1, -1, 0, -1, 0);
        n_checks++; if (ifr_cyc != 6) begin n_errors++; $display("FAIL rnd_if_cycle it%0d got %0d want 6", it, ifr_cyc); end
        n_checks++; if (obs_idata !== exp) begin n_errors++; $display("FAIL rnd_if_data it%0d got %h want %h", it, obs_idata, exp); end
        n_checks++; if (fin_cnt != 0) begin n_errors++; $display("FAIL rnd_if_nolsb it%0d got %0d want 0", it, fin_cnt); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] la = 32'h1230, fa = 32'h2000;
    logic [31:0] lexp = ref_load(la, 4), fexp = ref_load(fa, 4);
    run_op(1, 0, LEN_W, la, 0, 4'h5, 1, fa, -1, -1, 0, -1, 0);
    n_checks++; if (fin_cyc != 6) begin n_errors++; $display("FAIL b2b_load_cycle got %0d want 6", fin_cyc); end
    n_checks++; if (obs_rdata !== lexp) begin n_errors++; $display("FAIL b2b_load_data got %h want %h", obs_rdata, lexp); end
    n_checks++; if (ifr_cnt != 1) begin n_errors++; $display("FAIL b2b_fetch_count got %0d want 1", ifr_cnt); end
    n_checks++; if (ifr_cyc <= fin_cyc) begin n_errors++; $display("FAIL b2b_order got fetch c%0d load c%0d want fetch later", ifr_cyc, fin_cyc); end
    n_checks++; if (obs_idata !== fexp) begin n_errors++; $display("FAIL b2b_fetch_data got %h want %h", obs_idata, fexp); end
  endtask

  task automatic test_clear();
    logic [31:0] sv = 32'hDEADBEEF;
    run_op(1, 0, LEN_W, 32'h300, 0, 4'h1, 0, 0, 2, -1, 0, -1, 0);
    n_checks++; if (fin_cnt != 0) begin n_errors++; $display("FAIL clr_ld_pulse got %0d want 0", fin_cnt); end
    n_checks++; if (busy_log[3] !== 1'b0) begin n_errors++; $display("FAIL clr_ld_busy got %b want 0", busy_log[3]); end
    run_op(1, 1, LEN_W, 32'h340, sv, 4'h2, 0, 0, 2, -1, 0, -1, 0);
    for (int k = 0; k < 4; k++) ref_mem['h340 + k] = sv[8*k +: 8];
    n_checks++; if (fin_cnt != 0) begin n_errors++; $display("FAIL clr_st_pulse got %0d want 0", fin_cnt); end
    n_checks++;
    if (wq.size() != 4) begin
      n_errors++; $display("FAIL clr_st_beats got %0d want 4", wq.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (wq[k].a !== 32'h340 + 32'(k) || wq[k].d !== sv[8*k +: 8]) begin
          n_errors++; $display("FAIL clr_st_beat k%0d got %h/%h want %h/%h", k, wq[k].a, wq[k].d, 32'h340 + 32'(k), sv[8*k +: 8]);
        end
      end
    end
    run_op(1, 1, LEN_B, 32'h380, 32'h77, 4'h4, 0, 0, 0, -1, 0, -1, 0);
    n_checks++; if (wq.size() != 0) begin n_errors++; $display("FAIL clr_req_dropped got %0d writes want 0", wq.size()); end
    n_checks++; if (fin_cnt != 0) begin n_errors++; $display("FAIL clr_req_pulse got %0d want 0", fin_cnt); end
    n_checks++; if (busy_log[1] !== 1'b0) begin n_errors++; $display("FAIL clr_req_busy got %b want 0", busy_log[1]); end
  endtask

  task automatic test_rdy_stall();
    logic [31:0] fa = 32'h4440, fexp = ref_load(32'h4440, 4);
    logic [31:0] sv = 32'h0BADF00D;
    run_op(0, 0, 0, 0, 0, 0, 1, fa, -1, 2, 3, -1, 0);
    n_checks++; if (ifr_cyc != 9) begin n_errors++; $display("FAIL rdy_if_cycle got %0d want 9", ifr_cyc); end
    n_checks++; if (obs_idata !== fexp) begin n_errors++; $display("FAIL rdy_if_data got %h want %h", obs_idata, fexp); end
    for (int c = 2; c <= 5; c++) begin
      n_checks++; if (a_log[c] !== fa + 1) begin n_errors++; $display("FAIL rdy_addr_hold c%0d got %h want %h", c, a_log[c], fa + 1); end
    end
    for (int c = 0; c < 12; c++) begin
      n_checks++; if (wr_log[c] !== 1'b0) begin n_errors++; $display("FAIL rdy_if_wr c%0d got %b want 0", c, wr_log[c]); end
    end
    run_op(1, 1, LEN_W, 32'h4500, sv, 4'h6, 0, 0, -1, 2, 2, -1, 0);
    for (int k = 0; k < 4; k++) ref_mem['h4500 + k] = sv[8*k +: 8];
    n_checks++; if (fin_cyc != 7) begin n_errors++; $display("FAIL rdy_st_cycle got %0d want 7", fin_cyc); end
    n_checks++;
    if (wq.size() != 4) begin
      n_errors++; $display("FAIL rdy_st_beats got %0d want 4", wq.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (wq[k].a !== 32'h4500 + 32'(k) || wq[k].d !== sv[8*k +: 8]) begin
          n_errors++; $display("FAIL rdy_st_beat k%0d got %h/%h want %h/%h", k, wq[k].a, wq[k].d, 32'h4500 + 32'(k), sv[8*k +: 8]);
        end
      end
    end
  endtask

  task automatic test_io_store();
    run_op(1, 1, LEN_B, 32'h30000, 32'h5A, 4'h7, 0, 0, -1, -1, 0, -1, 5);
    n_checks++;
    if (wq.size() != 1) begin
      n_errors++; $display("FAIL io_beats got %0d want 1", wq.size());
    end else begin
      n_checks++;
      if (wq[0].a !== 32'h30000 || wq[0].d !== 8'h5A) begin
        n_errors++; $display("FAIL io_beat got %h/%h want 30000/5A", wq[0].a, wq[0].d);
      end
`ifdef MEM_IO_STALL_EN
      n_checks++; if (wq[0].cyc != 6) begin n_errors++; $display("FAIL io_beat_cycle got %0d want 6", wq[0].cyc); end
      n_checks++; if (fin_cnt != 1 || fin_cyc <= wq[0].cyc) begin n_errors++; $display("FAIL io_finish got c%0d n%0d want one after c%0d", fin_cyc, fin_cnt, wq[0].cyc); end
`else
      n_checks++; if (wq[0].cyc != 1) begin n_errors++; $display("FAIL io_beat_cycle got %0d want 1", wq[0].cyc); end
      n_checks++; if (fin_cyc != 2) begin n_errors++; $display("FAIL io_finish got %0d want 2", fin_cyc); end
`endif
    end
  endtask

  task automatic test_reset_mid();
    int late;
    run_op(1, 1, LEN_W, 32'h5000, 32'h12345678, 4'h8, 0, 0, -1, -1, 0, 2, 0);
    late = 0;
    foreach (wq[i]) if (wq[i].cyc >= 2) late++;
    n_checks++; if (late != 0) begin n_errors++; $display("FAIL rstmid_writes got %0d late writes want 0", late); end
    n_checks++; if (fin_cnt != 0) begin n_errors++; $display("FAIL rstmid_pulse got %0d want 0", fin_cnt); end
    n_checks++; if (busy_log[3] !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy got %b want 0", busy_log[3]); end
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    test_reset();
    test_load_word();
    test_store_half();
    test_random_ops();
    test_back_to_back();
    test_clear();
    test_rdy_stall();
    test_io_store();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
